// File: rtl/mips_ctrl_pkg.sv
// Shared types and default constants for the MIPS run sequencer.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    // Completion mailbox used by the test program: a store of 7 to 0x54.
    localparam logic [31:0] DEF_DONE_ADDR = 32'h0000_0054;
    localparam logic [31:0] DEF_DONE_DATA = 32'h0000_0007;

endpackage

// File: rtl/mips_store_monitor.sv
// Snoops core data-memory stores for the completion write.
module mips_store_monitor
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] DONE_ADDR = DEF_DONE_ADDR,
    parameter logic [31:0] DONE_DATA = DEF_DONE_DATA
) (
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        hit,
    output logic        hit_pass
);

    // Pure compare; the sequencer decides whether the hit is qualified.
    always_comb begin
        hit      = memwrite && (dataadr == DONE_ADDR);
        hit_pass = (writedata == DONE_DATA);
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run sequencer for the pipelined MIPS core: holds the core in reset,
// releases it on start, counts executed cycles and ends the run as
// pass / fail / timeout. Optional single-step support is enabled by
// defining MIPS_RUN_CTRL_STEP_EN.
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [31:0] DONE_ADDR    = DEF_DONE_ADDR,
    parameter logic [31:0] DONE_DATA    = DEF_DONE_DATA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic             core_memwrite,
    input  logic [31:0]      core_dataadr,
    input  logic [31:0]      core_writedata,
`ifdef MIPS_RUN_CTRL_STEP_EN
    input  logic             step_mode,
    input  logic             step,
    output logic             stepping,
`endif
    output logic             core_reset,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    run_state_t       state, state_next;
    logic [CNT_W-1:0] limit_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0] count_inc;
    logic             hit, hit_pass;
    logic             run_step, budget_hit, start_ok, en_ok;

    mips_store_monitor #(
        .DONE_ADDR(DONE_ADDR),
        .DONE_DATA(DONE_DATA)
    ) u_store_monitor (
        .memwrite (core_memwrite),
        .dataadr  (core_dataadr),
        .writedata(core_writedata),
        .hit      (hit),
        .hit_pass (hit_pass)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        run_step   = (state == RUN) && core_en;
        count_inc  = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        budget_hit = (limit_q != '0) && ((cycle_count + CNT_W'(1)) == limit_q);
        start_ok   = start && !abort && (state inside {IDLE, DONE, TIMEOUT});
`ifdef MIPS_RUN_CTRL_STEP_EN
        en_ok      = !step_mode || step;
`else
        en_ok      = 1'b1;
`endif
        case (state)
            IDLE, DONE, TIMEOUT: if (start_ok) state_next = HOLD;
            HOLD:                if (hold_cnt == HOLD_W'(1)) state_next = RUN;
            RUN: begin
                if (run_step && hit)             state_next = DONE;
                else if (run_step && budget_hit) state_next = TIMEOUT;
            end
            default:             state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // Registered outputs follow the next state so core_en drops on the
    // same edge that enters DONE/TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            limit_q     <= '0;
            hold_cnt    <= '0;
        end else begin
            core_reset <= (state_next == IDLE) || (state_next == HOLD);
            core_en    <= (state_next == RUN) && en_ok;
            busy       <= (state_next == HOLD) || (state_next == RUN);
            if (start_ok) begin
                limit_q     <= cycle_limit;
                done        <= 1'b0;
                pass        <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
                hold_cnt    <= HOLD_W'(RESET_CYCLES);
            end else if (!abort) begin
                if (state == HOLD) hold_cnt <= hold_cnt - HOLD_W'(1);
                if (run_step) begin
                    cycle_count <= count_inc;
                    if (hit) begin
                        done <= 1'b1;
                        pass <= hit_pass;
                    end else if (budget_hit) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef MIPS_RUN_CTRL_STEP_EN
    // Step-mode indicator, registered alongside the other outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stepping <= 1'b0;
        else        stepping <= step_mode && (state_next == RUN);
    end
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed and randomized runs
// checked against an outcome model derived from limit / store cycle.
`timescale 1ns/1ps
module tb_mips_run_ctrl;

    localparam int unsigned CNT_W        = 32;
    localparam int unsigned RESET_CYCLES = 2;
    localparam logic [31:0] DONE_ADDR    = 32'h0000_0054;
    localparam logic [31:0] DONE_DATA    = 32'h0000_0007;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cycle_limit;
    logic             core_memwrite;
    logic [31:0]      core_dataadr;
    logic [31:0]      core_writedata;
    logic             core_reset, core_en, busy, done, pass, timeout;
    logic [CNT_W-1:0] cycle_count;
`ifdef MIPS_RUN_CTRL_STEP_EN
    logic             step_mode, step, stepping;
`endif

    int vectors    = 0;
    int miscompares = 0;

    mips_run_ctrl #(
        .CNT_W       (CNT_W),
        .RESET_CYCLES(RESET_CYCLES),
        .DONE_ADDR   (DONE_ADDR),
        .DONE_DATA   (DONE_DATA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cycle_limit   (cycle_limit),
        .core_memwrite (core_memwrite),
        .core_dataadr  (core_dataadr),
        .core_writedata(core_writedata),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step_mode     (step_mode),
        .step          (step),
        .stepping      (stepping),
`endif
        .core_reset    (core_reset),
        .core_en       (core_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_bus();
        core_memwrite  = 1'b0;
        core_dataadr   = $urandom;
        core_writedata = $urandom;
    endtask

    // One full run. store_cyc = RUN cycle (1-based) carrying the completion
    // store (0 = none); noise_cyc = cycle with a store of 5 to 0x04;
    // restart_cyc = cycle where a start pulse is issued while busy.
    task automatic run_case(input string name, input logic [31:0] limit, input int store_cyc,
                            input logic [31:0] data, input int noise_cyc, input int restart_cyc);
        int   hold_seen = 0;
        int   run_seen  = 0;
        int   guard     = 0;
        bit   ended     = 0;
        logic exp_done, exp_pass, exp_to;
        logic [31:0] exp_cnt;
        logic [31:0] a;

        // Outcome model: the completion store ends the run if it lands
        // within the budget (ties go to completion), else the budget does.
        if (store_cyc != 0 && (limit == 0 || store_cyc <= int'(limit))) begin
            exp_done = 1'b1; exp_pass = (data == DONE_DATA); exp_to = 1'b0; exp_cnt = store_cyc;
        end else begin
            exp_done = 1'b0; exp_pass = 1'b0; exp_to = 1'b1; exp_cnt = limit;
        end

        @(negedge clk);
        start = 1'b1; cycle_limit = limit;
        @(negedge clk);
        cycle_limit = $urandom;
        while (guard < 3000) begin
            start = 1'b0;
            if (!busy) begin ended = 1; break; end
            if (core_reset) hold_seen++;
            idle_bus();
            if (core_en) begin
                run_seen++;
                if (run_seen == store_cyc) begin
                    core_memwrite = 1'b1; core_dataadr = DONE_ADDR; core_writedata = data;
                end else if (run_seen == noise_cyc) begin
                    core_memwrite = 1'b1; core_dataadr = 32'h4; core_writedata = 32'h5;
                end else if ($urandom_range(0, 3) == 0) begin
                    a = $urandom & 32'hFFFF_FFFC;
                    if (a == DONE_ADDR) a = a ^ 32'h4;
                    core_memwrite = 1'b1; core_dataadr = a; core_writedata = DONE_DATA;
                end
                if (run_seen == restart_cyc) begin
                    start = 1'b1; cycle_limit = 3;
                end
            end
            @(negedge clk);
            guard++;
        end
        idle_bus();
        check({name, "_ended"}, ended, 1'b1);
        check({name, "_hold"}, hold_seen, RESET_CYCLES);
        check({name, "_core_cycles"}, run_seen, exp_cnt);
        check({name, "_done"}, done, exp_done);
        check({name, "_pass"}, pass, exp_pass);
        check({name, "_timeout"}, timeout, exp_to);
        check({name, "_count"}, cycle_count, exp_cnt);
        check({name, "_core_en"}, core_en, 1'b0);
        check({name, "_core_reset"}, core_reset, 1'b0);
        // Frozen state keeps its results.
        repeat (2) @(negedge clk);
        check({name, "_count_held"}, cycle_count, exp_cnt);
        check({name, "_done_held"}, done, exp_done);
        check({name, "_en_held"}, core_en, 1'b0);
    endtask

    // Run with no limit-driven end; abort issued after abort_after core cycles.
    task automatic run_abort(input string name, input logic [31:0] limit, input int abort_after);
        int run_seen = 0;
        int guard    = 0;
        @(negedge clk);
        start = 1'b1; cycle_limit = limit;
        @(negedge clk);
        start = 1'b0;
        while (guard < 3000 && run_seen <= abort_after) begin
            idle_bus();
            if (core_en) run_seen++;
            if (run_seen == abort_after + 1) begin
                check({name, "_busy_before"}, busy, 1'b1);
                check({name, "_count_before"}, cycle_count, abort_after);
                abort = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        abort = 1'b0;
        check({name, "_reached"}, run_seen, abort_after + 1);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_core_reset"}, core_reset, 1'b1);
        check({name, "_core_en"}, core_en, 1'b0);
        check({name, "_count"}, cycle_count, abort_after);
        check({name, "_flags"}, {done, pass, timeout}, 3'b000);
    endtask

    initial begin
        logic [31:0] lim, dat;
        int sc;
        reset = 1'b0; start = 1'b0; abort = 1'b0; cycle_limit = '0;
        idle_bus();
`ifdef MIPS_RUN_CTRL_STEP_EN
        step_mode = 1'b0; step = 1'b0;
`endif
        #12;
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_core_en", core_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {done, pass, timeout}, 3'b000);
        check("rst_count", cycle_count, 0);
        #10 reset = 1'b1;

        run_case("pass", 25, 18, DONE_DATA, 0, 5);
        run_case("fail", 25, 18, 32'h5, 0, 0);
        run_case("tmo", 25, 0, 32'h0, 3, 7);
        run_case("tie", 25, 25, DONE_DATA, 0, 0);
        run_abort("abort10", 25, 10);
        run_abort("unlim", 0, 1000);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cycle_limit = 25;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 1'b0);

        for (int r = 0; r < 10; r++) begin
            lim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(4, 40));
            sc  = $urandom_range(0, 45);
            if (lim == 0 && sc == 0) sc = 20;
            dat = $urandom_range(0, 1) ? DONE_DATA : 32'($urandom_range(0, 15));
            run_case("rand", lim, sc, dat, $urandom_range(1, 3), $urandom_range(2, 6));
        end

        // Asynchronous reset while in HOLD.
        @(negedge clk);
        start = 1'b1; cycle_limit = 25;
        @(negedge clk);
        start = 1'b0;
        check("hold_busy", busy, 1'b1);
        check("hold_core_reset", core_reset, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_core_reset", core_reset, 1'b1);
        check("arst_core_en", core_en, 1'b0);
        #1 reset = 1'b1;
        @(negedge clk);
        check("arst_stays_idle", busy, 1'b0);

`ifdef MIPS_RUN_CTRL_STEP_EN
        begin
            int en_seen = 0;
            step_mode = 1'b1;
            @(negedge clk);
            start = 1'b1; cycle_limit = 0;
            @(negedge clk);
            start = 1'b0;
            repeat (RESET_CYCLES + 2) @(negedge clk);
            check("step_stepping", stepping, 1'b1);
            for (int i = 0; i < 30; i++) begin
                if (core_en) en_seen++;
                step = (i == 3 || i == 9 || i == 17);
                @(negedge clk);
            end
            step = 1'b0;
            check("step_en_cycles", en_seen, 3);
            check("step_count", cycle_count, 3);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0; step_mode = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
